tt_um_koggestone_subtractor4: RTL and testbench
===============================================

// Module: tt_um_koggestone_subtractor4
// PURPOSE
//  Inverse companion of the 4-bit Kogge-Stone adder tile: takes an adder result {carry_out,sum}
//  and operand b, recovers operand a = {carry_out,sum} - b with a pipelined 5-bit Kogge-Stone
//  subtractor (M + ~B + 1). Flags inputs no 4-bit addition could produce and counts them.
//  Sits as a standalone Tiny Tapeout user tile on the standard tt_um pin map.
// PARAMETERS
//  PIPE      1   1: register prefix stage-1 (latency 2); 0: no mid register (latency 1)
//  CNT_W     2   width of saturating error counter (must fit uo_out[7:6], so 2)
// PORTS
//  clk       in   1  clock, all state on rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  ena       in   1  tile enable, always 1 when powered; ignored
//  ui_in     in   8  [3:0] sum, [4] carry_out, [7:5] unused
//  uio_in    in   8  [3:0] operand b, [4] valid_in, [7:5] unused
//  uo_out    out  8  [3:0] a, [4] err, [5] valid_out, [7:6] err_cnt
//  uio_out   out  8  tied 8'h00
//  uio_oe    out  8  tied 8'h00 (all uio pins inputs)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk release): a=0, err=0, valid_out=0, err_cnt=0,
//    all pipeline valid bits 0; uio_out/uio_oe constant 0 regardless of reset.
//  - Arithmetic: M={1'b0? no: ui_in[4],ui_in[3:0]} 5b; B={1'b0,uio_in[3:0]} 5b.
//    p=M^~B, g=M&~B, cin=1 folded into bit0 generate: g0'=g0|p0.
//    Prefix: stage1 span 1, stage2 span 2, stage3 span 4 (5 bits needs 3 levels).
//    D[i]=p[i]^c[i]; cout5 = final group generate over bits 4..0.
//  - a = D[3:0] (i.e. (M-B) mod 16). err = ~cout5 (M<B, borrow) | D[4] (result >15).
//    err=0 exactly when M=a0+b for some 4-bit a0; then a==a0.
//  - Pipeline: input sampled at edge where valid_in=1. PIPE=1: stage-1 p/g regs + valid at
//    that edge, outputs regs at next edge -> valid_out high 2 cycles after sample edge.
//    PIPE=0: outputs registered at sample edge -> latency 1.
//  - Throughput 1 result/cycle, no backpressure; results emerge in input order.
//  - valid_out is a 1-cycle pulse per accepted input. When valid_out=0, a and err hold last
//    result (not cleared).
//  - valid_in=0: stage carries no item, nothing retired, err_cnt unchanged.
//  - err_cnt increments by 1 on each retired result with err=1; saturates at 2^CNT_W-1,
//    never wraps; cleared only by reset.
//  - Reset mid-operation: in-flight items discarded, no valid_out for them after release.
//  - ui_in[7:5], uio_in[7:5], ena have no effect on any output.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> uo_out=8'h00, uio_out=uio_oe=8'h00;
//    assert rst_n=0 between edges -> outputs 0 immediately (async).
//  2 {cout,sum}=5'h12, b=5, valid_in 1 cycle -> 2 cycles later valid_out=1, a=4'hD, err=0;
//    next cycle valid_out=0, a stays 4'hD.
//  3 {cout,sum}=5'h03, b=9 -> a=4'hA, err=1, err_cnt=1; then 3 more error inputs ->
//    err_cnt=3 and stays 3 (saturation).
//  4 Back-to-back valid_in for 4 cycles (M,b)=(5,2),(16,1),(0,0),(31,15) -> 4 consecutive
//    valid_out pulses: a=3/err0, F/err0, 0/err0, 0/err1 (16 >15), in order.
//  5 Issue item, assert rst_n=0 one cycle later, release -> no valid_out ever, err_cnt=0.
//  6 Exhaustive: all 256 (a0,b) pairs -> feed a0+b, b; every result a==a0, err=0;
//    repeat with PIPE=0 checking latency 1.

Source files
------------

// File: rtl/tt_um_koggestone_subtractor4.sv
// Recovers operand a = {carry_out,sum} - b with a 5-bit Kogge-Stone subtractor (M + ~B + 1),
// flagging and counting results no 4-bit addition could have produced.
module tt_um_koggestone_subtractor4 #(
  parameter int PIPE  = 1,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [4:0] m, nb, p0, g_raw, g0;
  logic [4:0] g1, p1;
  logic [4:0] g1_s, p1_s, p0_s;
  logic       v_s;
  logic [4:0] g2, p2, g3;
  logic [4:0] carry, diff;
  logic       err_c;

  logic [3:0]       a_q;
  logic             err_q;
  logic             valid_q;
  logic [CNT_W-1:0] err_cnt;

  // Carry-in of 1 is folded into bit 0 so the prefix tree needs no separate cin term.
  always_comb begin
    m     = ui_in[4:0];
    nb    = ~{1'b0, uio_in[3:0]};
    p0    = m ^ nb;
    g_raw = m & nb;
    g0    = {g_raw[4:1], g_raw[0] | p0[0]};
    g1    = g0;
    p1    = p0;
    for (int i = 1; i < 5; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
  end

  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_s  <= 1'b0;
        g1_s <= '0;
        p1_s <= '0;
        p0_s <= '0;
      end else begin
        v_s <= uio_in[4];
        if (uio_in[4]) begin
          g1_s <= g1;
          p1_s <= p1;
          p0_s <= p0;
        end
      end
    end
  end else begin : g_comb
    always_comb begin
      v_s  = uio_in[4];
      g1_s = g1;
      p1_s = p1;
      p0_s = p0;
    end
  end

  // Span-2 then span-4 levels; after span 4 every group reaches bit 0.
  always_comb begin
    g2 = g1_s;
    p2 = p1_s;
    for (int i = 2; i < 5; i++) begin
      g2[i] = g1_s[i] | (p1_s[i] & g1_s[i-2]);
      p2[i] = p1_s[i] & p1_s[i-2];
    end
    g3    = g2;
    g3[4] = g2[4] | (p2[4] & g2[0]);
    carry = {g3[3:0], 1'b1};
    diff  = p0_s ^ carry;
    err_c = ~g3[4] | diff[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      valid_q <= v_s;
      if (v_s) begin
        a_q   <= diff[3:0];
        err_q <= err_c;
        if (err_c && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign uo_out  = {err_cnt, valid_q, err_q, a_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused;
  assign unused = &{1'b0, ena, ui_in[7:5], uio_in[7:5], p2[3:0]};

endmodule

// File: tb/tb_tt_um_koggestone_subtractor4.sv
// Randomized and directed checks of both pipeline variants against an arithmetic reference.
module tb_tt_um_koggestone_subtractor4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo1, uioo1, uoe1;
  logic [7:0] uo0, uioo0, uoe0;

  always #5 clk = ~clk;

  tt_um_koggestone_subtractor4 #(.PIPE(1), .CNT_W(2)) u_p1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uioo1), .uio_oe(uoe1)
  );

  tt_um_koggestone_subtractor4 #(.PIPE(0), .CNT_W(2)) u_p0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo0), .uio_out(uioo0), .uio_oe(uoe0)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] a;
    logic       e;
  } item_t;

  // h0: item accepted at the latest edge, h1: the one before it
  item_t      h0, h1;
  logic [3:0] ma [2];
  logic       me [2];
  int         mc [2];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic item_t ref_item(input int m, input int b, input bit v);
    item_t r;
    int d;
    d = m - b;
    r.v = v;
    r.a = 4'(d & 15);
    r.e = (d < 0) || (d > 15);
    return r;
  endfunction

  task automatic retire(input int k, input item_t it);
    if (it.v) begin
      ma[k] = it.a;
      me[k] = it.e;
      if (it.e && mc[k] < 3) mc[k]++;
    end
  endtask

  function automatic logic [7:0] exp_uo(input int k, input logic v);
    return {2'(mc[k]), v, me[k], ma[k]};
  endfunction

  // Called at a negedge; returns at the following negedge after checking both variants.
  task automatic step(input int m, input int b, input bit v);
    ui_in  = {3'($urandom), 5'(m)};
    uio_in = {3'($urandom), v, 4'(b)};
    ena    = 1'($urandom);
    @(posedge clk);
    h1 = h0;
    h0 = ref_item(m, b, v);
    retire(1, h1);
    retire(0, h0);
    @(negedge clk);
    chk("uo_pipe1", {8'h0, uo1}, {8'h0, exp_uo(1, h1.v)});
    chk("uo_pipe0", {8'h0, uo0}, {8'h0, exp_uo(0, h0.v)});
    chk("uio_pipe1", {uioo1, uoe1}, 16'h0000);
    chk("uio_pipe0", {uioo0, uoe0}, 16'h0000);
  endtask

  // Called at a negedge; asserts reset between edges and releases it at a later negedge.
  task automatic do_reset();
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    rst_n  = 1'b0;
    #1;
    chk("async_rst_p1", {8'h0, uo1}, 16'h0000);
    chk("async_rst_p0", {8'h0, uo0}, 16'h0000);
    h0 = '0;
    h1 = '0;
    for (int k = 0; k < 2; k++) begin
      ma[k] = '0;
      me[k] = 1'b0;
      mc[k] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      chk("rst_hold", {uo1, uo0}, 16'h0000);
      chk("rst_uio", {uioo1 | uioo0, uoe1 | uoe0}, 16'h0000);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // single good item, then hold
    step(18, 5, 1);
    step(0, 0, 0);
    chk("t2_valid", {10'h0, uo1[5:0]}, 16'h002D);
    step(0, 0, 0);
    chk("t2_hold", {10'h0, uo1[5:0]}, 16'h000D);

    // error items and counter saturation
    step(3, 9, 1);
    step(0, 0, 0);
    chk("t3_err", {8'h0, uo1}, 16'h007A);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(0, 0, 0);
    chk("t3_sat", {14'h0, uo1[7:6]}, 16'h0003);
    step(31, 0, 1);
    step(0, 0, 0);
    chk("t3_nowrap", {14'h0, uo1[7:6]}, 16'h0003);

    // back-to-back items
    step(5, 2, 1);
    step(16, 1, 1);
    chk("t4_0", {10'h0, uo1[5:0]}, 16'h0023);
    step(0, 0, 1);
    chk("t4_1", {10'h0, uo1[5:0]}, 16'h002F);
    step(31, 15, 1);
    chk("t4_2", {10'h0, uo1[5:0]}, 16'h0020);
    step(0, 0, 0);
    chk("t4_3", {10'h0, uo1[5:0]}, 16'h0030);

    // reset while an item is in flight
    do_reset();
    step(4, 9, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("t5_drop", {13'h0, uo1[7:5]}, 16'h0000);
    end

    // exhaustive valid sums
    for (int a0 = 0; a0 < 16; a0++)
      for (int b = 0; b < 16; b++) begin
        step(a0 + b, b, 1);
        chk("ex_pipe0", {10'h0, uo0[5:0]}, {10'h0, 2'b10, 4'(a0)});
      end
    step(0, 0, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else step(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
